// File: rtl/l2_tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l2_tlb_pkg
// Purpose : Widths, entry layout, FSM states and entry helpers for l2_tlb_ctrl.
// Revision: 1.0
// ============================================================================
package l2_tlb_pkg;

  localparam int TLB_IDX_W   = 10;
  localparam int TLB_VPN_W   = 19;
  localparam int TLB_TAG_W   = TLB_VPN_W - TLB_IDX_W;
  localparam int TLB_PPN_W   = 20;
  localparam int TLB_PERM_W  = 8;
  localparam int TLB_RSVD_W  = 5;
  localparam int TLB_ENTRY_W = 44;

  localparam int ENT_V_BIT    = 43;
  localparam int ENT_TAG_LSB  = 34;
  localparam int ENT_PPN_LSB  = 14;
  localparam int ENT_PERM_LSB = 6;
  localparam int ENT_PAR_BIT  = 0;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  v;
    logic [TLB_TAG_W-1:0]  tag;
    logic [TLB_PPN_W-1:0]  ppn;
    logic [TLB_PERM_W-1:0] perm;
    logic [TLB_RSVD_W-1:0] rsvd;
    logic                  par;
  } entry_t;

  function automatic logic [TLB_ENTRY_W-1:0] entry_pack(input entry_t e);
    logic [TLB_ENTRY_W-1:0] w;
    w                                       = '0;
    w[ENT_V_BIT]                            = e.v;
    w[ENT_TAG_LSB +: TLB_TAG_W]             = e.tag;
    w[ENT_PPN_LSB +: TLB_PPN_W]             = e.ppn;
    w[ENT_PERM_LSB +: TLB_PERM_W]           = e.perm;
    w[ENT_PAR_BIT+1 +: TLB_RSVD_W]          = e.rsvd;
    w[ENT_PAR_BIT]                          = e.par;
    return w;
  endfunction

  function automatic entry_t entry_unpack(input logic [TLB_ENTRY_W-1:0] w);
    entry_t e;
    e.v    = w[ENT_V_BIT];
    e.tag  = w[ENT_TAG_LSB +: TLB_TAG_W];
    e.ppn  = w[ENT_PPN_LSB +: TLB_PPN_W];
    e.perm = w[ENT_PERM_LSB +: TLB_PERM_W];
    e.rsvd = w[ENT_PAR_BIT+1 +: TLB_RSVD_W];
    e.par  = w[ENT_PAR_BIT];
    return e;
  endfunction

  // Even parity over every bit above the parity bit itself.
  function automatic logic entry_parity(input logic [TLB_ENTRY_W-1:0] w);
    return ^w[TLB_ENTRY_W-1:ENT_PAR_BIT+1];
  endfunction

endpackage : l2_tlb_pkg
`default_nettype wire

// File: rtl/l2_tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : l2_tlb_ctrl
// Purpose : Lookup/refill arbiter, tag compare and invalidate sweep in front of
//           the 1024x44 single-port L2 TLB SRAM. Option: L2_TLB_PARITY_EN.
// Revision: 1.0
// ============================================================================
module l2_tlb_ctrl
  import l2_tlb_pkg::*;
#(
  parameter int IDX_W  = TLB_IDX_W,
  parameter int VPN_W  = TLB_VPN_W,
  parameter int PPN_W  = TLB_PPN_W,
  parameter int PERM_W = TLB_PERM_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [VPN_W-1:0]       req_vpn,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [PPN_W-1:0]       resp_ppn,
  output logic [PERM_W-1:0]      resp_perm,
  input  logic                   refill_valid,
  output logic                   refill_ready,
  input  logic [VPN_W-1:0]       refill_vpn,
  input  logic [PPN_W-1:0]       refill_ppn,
  input  logic [PERM_W-1:0]      refill_perm,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   parity_err,
  output logic [IDX_W-1:0]       sram_addr,
  output logic                   sram_en,
  output logic                   sram_wmode,
  output logic [TLB_ENTRY_W-1:0] sram_wdata,
  input  logic [TLB_ENTRY_W-1:0] sram_rdata
);

  generate
    if ((1 + (VPN_W - IDX_W) + PPN_W + PERM_W + 6 != TLB_ENTRY_W) ||
        (IDX_W != TLB_IDX_W) || (VPN_W != TLB_VPN_W) ||
        (PPN_W != TLB_PPN_W) || (PERM_W != TLB_PERM_W)) begin : g_width_check
      $error("l2_tlb_ctrl: field widths do not form the 44-bit entry layout");
    end
  endgenerate

  state_t                 r_state;
  logic [IDX_W-1:0]       r_sweep_cnt;
  logic                   r_flush_pend;
  logic [VPN_W-IDX_W-1:0] r_tag;
  logic                   r_resp_valid;
  logic                   r_resp_hit;
  logic [PPN_W-1:0]       r_resp_ppn;
  logic [PERM_W-1:0]      r_resp_perm;
  logic                   r_parity_err;

  logic                   w_flush_pend;
  logic                   w_idle_free;
  logic                   w_refill_fire;
  logic                   w_req_fire;
  logic [TLB_ENTRY_W-1:0] w_refill_word;
  entry_t                 w_rd;
  logic                   w_par_bad;
  logic                   w_hit;
  logic                   w_unused;

  // A flush_req arriving in IDLE blocks new work that same cycle.
  assign w_flush_pend  = r_flush_pend | flush_req;
  assign w_idle_free   = (r_state == ST_IDLE) && !w_flush_pend;
  assign refill_ready  = w_idle_free;
  assign req_ready     = w_idle_free && !refill_valid;
  assign w_refill_fire = refill_valid && refill_ready;
  assign w_req_fire    = req_valid && req_ready;

  assign flush_busy = (r_state == ST_FLUSH);
  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign resp_ppn   = r_resp_ppn;
  assign resp_perm  = r_resp_perm;
  assign parity_err = r_parity_err;

  always_comb begin
    entry_t e;
    e.v           = 1'b1;
    e.tag         = refill_vpn[VPN_W-1:IDX_W];
    e.ppn         = refill_ppn;
    e.perm        = refill_perm;
    e.rsvd        = '0;
    e.par         = 1'b0;
    w_refill_word = entry_pack(e);
`ifdef L2_TLB_PARITY_EN
    w_refill_word[ENT_PAR_BIT] = entry_parity(w_refill_word);
`endif
  end

  assign w_rd = entry_unpack(sram_rdata);
`ifdef L2_TLB_PARITY_EN
  assign w_par_bad = w_rd.v && (entry_parity(sram_rdata) != w_rd.par);
`else
  assign w_par_bad = 1'b0;
`endif
  assign w_hit    = w_rd.v && (w_rd.tag == r_tag) && !w_par_bad;
  assign w_unused = ^{w_rd.rsvd, w_rd.par};

  // Sweep writes are held off while reset is asserted.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (r_state == ST_FLUSH) begin
      sram_en    = reset_n;
      sram_wmode = 1'b1;
      sram_addr  = r_sweep_cnt;
    end else if (w_refill_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = refill_vpn[IDX_W-1:0];
      sram_wdata = w_refill_word;
    end else if (w_req_fire) begin
      sram_en    = 1'b1;
      sram_addr  = req_vpn[IDX_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_FLUSH;
      r_sweep_cnt  <= '0;
      r_flush_pend <= 1'b0;
      r_tag        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_ppn   <= '0;
      r_resp_perm  <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      case (r_state)
        ST_FLUSH: begin
          r_flush_pend <= 1'b0;
          if (flush_req) begin
            r_sweep_cnt <= '0;
          end else if (r_sweep_cnt == '1) begin
            r_sweep_cnt <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_flush_pend) begin
            r_flush_pend <= 1'b0;
            r_sweep_cnt  <= '0;
            r_state      <= ST_FLUSH;
          end else if (w_req_fire) begin
            r_tag   <= req_vpn[VPN_W-1:IDX_W];
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (flush_req) r_flush_pend <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_hit   <= w_hit;
          r_resp_ppn   <= w_hit ? w_rd.ppn : '0;
          r_resp_perm  <= w_hit ? w_rd.perm : '0;
          r_parity_err <= w_par_bad;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (flush_req) r_flush_pend <= 1'b1;
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_ppn   <= '0;
            r_resp_perm  <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_FLUSH;
      endcase
    end
  end

endmodule : l2_tlb_ctrl
`default_nettype wire

// File: tb/tb_l2_tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_l2_tlb_ctrl
// Purpose : Directed plus random self-checking bench with SRAM and TLB models.
// Revision: 1.0
// ============================================================================
module tb_l2_tlb_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_hit;
  logic [18:0] req_vpn, refill_vpn;
  logic [19:0] resp_ppn, refill_ppn;
  logic [7:0]  resp_perm, refill_perm;
  logic        refill_valid, refill_ready, flush_req, flush_busy, parity_err;
  logic [9:0]  sram_addr;
  logic        sram_en, sram_wmode;
  logic [43:0] sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural SRAM with a fault-injection mask on the read port.
  logic [43:0] mem [1024];
  logic [43:0] mem_q = '0;
  logic [43:0] sram_flip = '0;
  logic        scramble = 1'b0;
  assign sram_rdata = mem_q ^ sram_flip;

  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < 1024; i++) mem[i] <= {$urandom(), $urandom()} | 44'h1;
    end else if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            mem_q <= mem[sram_addr];
    end
  end

  // Reference TLB: direct-mapped by vpn[9:0], tag vpn[18:10].
  bit          m_valid [1024];
  logic [8:0]  m_tag   [1024];
  logic [19:0] m_ppn   [1024];
  logic [7:0]  m_perm  [1024];

  always #5 clock = ~clock;

  l2_tlb_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_ppn(resp_ppn), .resp_perm(resp_perm),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_vpn(refill_vpn), .refill_ppn(refill_ppn), .refill_perm(refill_perm),
    .flush_req(flush_req), .flush_busy(flush_busy), .parity_err(parity_err),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
  endtask

  // Expects a sweep to start within a few cycles; optionally restarts it.
  task automatic check_sweep(input int restart_at, input int exp_total);
    int w = 0, cyc = 0, bad = 0, exp_addr = 0, nz = 0;
    #1;
    while (!flush_busy && w < 10) begin @(negedge clock); #1; w++; end
    while (flush_busy && cyc < 4000) begin
      if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_addr === 10'(exp_addr) &&
            sram_wdata === 44'h0 && req_ready === 1'b0 && refill_ready === 1'b0)) bad++;
      if (cyc == restart_at) begin flush_req = 1'b1; exp_addr = 0; end
      else exp_addr++;
      @(negedge clock); flush_req = 1'b0; #1; cyc++;
    end
    chk("sweep_len", 64'(cyc), 64'(exp_total));
    chk("sweep_ctl", 64'(bad), 64'h0);
    for (int i = 0; i < 1024; i++) if (mem[i] !== 44'h0) nz++;
    chk("sweep_clear", 64'(nz), 64'h0);
    chk("post_sweep_ready", 64'(req_ready), 64'h1);
    model_clear();
  endtask

  task automatic refill(input logic [18:0] vpn, input logic [19:0] ppn, input logic [7:0] perm);
    int w = 0;
    logic [43:0] exp_word;
    logic [9:0]  idx;
    idx = vpn[9:0];
    exp_word = {1'b1, vpn[18:10], ppn, perm, 5'b0, 1'b0};
`ifdef L2_TLB_PARITY_EN
    exp_word[0] = ^exp_word[43:1];
`endif
    refill_vpn = vpn; refill_ppn = ppn; refill_perm = perm; refill_valid = 1'b1;
    #1;
    while (!refill_ready && w < 20) begin @(negedge clock); #1; w++; end
    chk("refill_ready", 64'(refill_ready), 64'h1);
    chk("refill_write", {8'h0, sram_en, sram_wmode, sram_addr, sram_wdata},
        {8'h0, 1'b1, 1'b1, idx, exp_word});
    @(posedge clock); @(negedge clock);
    refill_valid = 1'b0;
    m_valid[idx] = 1'b1; m_tag[idx] = vpn[18:10]; m_ppn[idx] = ppn; m_perm[idx] = perm;
  endtask

  task automatic lookup(input logic [18:0] vpn, input int hold, input logic [43:0] flip,
                        input bit flush_in_resp);
    int w = 0, unstable = 0, perr = 0;
    logic [9:0]  idx;
    bit          tag_ok, exp_perr, exp_hit;
    logic [19:0] exp_ppn;
    logic [7:0]  exp_perm;
    idx    = vpn[9:0];
    tag_ok = m_valid[idx] && (m_tag[idx] == vpn[18:10]);
`ifdef L2_TLB_PARITY_EN
    exp_perr = m_valid[idx] && ($countones(flip) % 2 == 1);
`else
    exp_perr = 1'b0;
`endif
    exp_hit  = tag_ok && !exp_perr;
    exp_ppn  = exp_hit ? (m_ppn[idx] ^ flip[33:14]) : 20'h0;
    exp_perm = exp_hit ? (m_perm[idx] ^ flip[13:6]) : 8'h0;

    req_vpn = vpn; req_valid = 1'b1;
    #1;
    while (!req_ready && w < 20) begin @(negedge clock); #1; w++; end
    chk("req_ready", 64'(req_ready), 64'h1);
    chk("read_issue", {52'h0, sram_en, sram_wmode, sram_addr}, {52'h0, 1'b1, 1'b0, idx});
    sram_flip = flip;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    chk("resp_lat_t1", 64'(resp_valid), 64'h0);
    perr += int'(parity_err);
    @(negedge clock);
    sram_flip = '0;
    chk("resp_lat_t2", 64'(resp_valid), 64'h1);
    chk("resp_hit", 64'(resp_hit), 64'(exp_hit));
    chk("resp_ppn", 64'(resp_ppn), 64'(exp_ppn));
    chk("resp_perm", 64'(resp_perm), 64'(exp_perm));
    chk("perr_first", 64'(parity_err), 64'(exp_perr));
    perr += int'(parity_err);
    for (int i = 0; i < hold; i++) begin
      if (flush_in_resp && i == 0) flush_req = 1'b1;
      @(negedge clock); flush_req = 1'b0; #1;
      if (resp_valid !== 1'b1 || resp_hit !== exp_hit || resp_ppn !== exp_ppn ||
          resp_perm !== exp_perm || req_ready !== 1'b0) unstable++;
      perr += int'(parity_err);
    end
    if (hold > 0) chk("resp_hold", 64'(unstable), 64'h0);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("resp_done", 64'(resp_valid), 64'h0);
    perr += int'(parity_err);
    chk("perr_pulses", 64'(perr), 64'(exp_perr));
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_vpn = '0; resp_ready = 1'b0;
    refill_valid = 1'b0; refill_vpn = '0; refill_ppn = '0; refill_perm = '0;
    flush_req = 1'b0;
    model_clear();
    scramble = 1'b1;
    @(negedge clock); scramble = 1'b0;
    @(negedge clock);
    chk("rst_flush_busy", 64'(flush_busy), 64'h1);
    chk("rst_sram_en", 64'(sram_en), 64'h0);
    chk("rst_ready", {62'h0, req_ready, refill_ready}, 64'h0);
    chk("rst_resp", {resp_valid, resp_hit, parity_err, resp_ppn, resp_perm}, 64'h0);

    reset_n = 1'b1;
    check_sweep(-1, 1024);

    refill(19'h12345, 20'hABCDE, 8'h5A);
    lookup(19'h12345, 0, '0, 1'b0);
    lookup(19'h52345, 0, '0, 1'b0);
    lookup(19'h12345, 5, '0, 1'b0);

    // Refill and lookup offered together: refill must win.
    refill_vpn = 19'h0A077; refill_ppn = 20'h13579; refill_perm = 8'hC3; refill_valid = 1'b1;
    req_vpn = 19'h0A077; req_valid = 1'b1;
    #1;
    chk("arb_refill_ready", 64'(refill_ready), 64'h1);
    chk("arb_req_stall", 64'(req_ready), 64'h0);
    @(posedge clock); @(negedge clock);
    refill_valid = 1'b0; req_valid = 1'b0;
    m_valid[10'h077] = 1'b1; m_tag[10'h077] = 9'h028;
    m_ppn[10'h077] = 20'h13579; m_perm[10'h077] = 8'hC3;
    lookup(19'h0A077, 0, '0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [18:0] v;
      v = {7'h0, 2'($urandom_range(0, 3)), 7'h0, 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 1) == 0) refill(v, 20'($urandom()), 8'($urandom()));
      else lookup(v, int'($urandom_range(0, 2)), '0, 1'b0);
    end

`ifdef L2_TLB_PARITY_EN
    refill(19'h00155, 20'h0F0F0, 8'h11);
    lookup(19'h00155, 1, 44'h1 << 20, 1'b0);
    lookup(19'h00155, 0, '0, 1'b0);
`endif

    lookup(19'h12345, 3, '0, 1'b1);
    check_sweep(500, 1525);
    lookup(19'h12345, 0, '0, 1'b0);

    // Reset while a lookup is in flight.
    refill(19'h12345, 20'h00042, 8'h24);
    req_vpn = 19'h12345; req_valid = 1'b1;
    #1;
    chk("mid_req_ready", 64'(req_ready), 64'h1);
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0; reset_n = 1'b0;
    #1;
    chk("mid_rst_state", {61'h0, flush_busy, resp_valid, sram_en}, {61'h0, 3'b100});
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    check_sweep(-1, 1024);
    lookup(19'h12345, 0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_l2_tlb_ctrl
`default_nettype wire
